wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter CNT_W, default 64, meaning width of the retired-write counter.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port pc_plus4_i  input  32  writeback candidate for return address.
REQ-005 The block SHALL have port alu_result_i  input  32  writeback candidate from ALU.
REQ-006 The block SHALL have port mem_rd_data_i  input  32  writeback candidate from data memory.
REQ-007 The block SHALL have port data_dest_i  input  2  writeback source select.
REQ-008 The block SHALL have port reg_wr_addr_i  input  5  destination register index.
REQ-009 The block SHALL have port reg_wr_sig_i  input  1  write enable from pipeline.
REQ-010 The block SHALL have ports rs1_addr_i, rs2_addr_i  input  5 each  decode-stage read indices.
REQ-011 The block SHALL have ports rs1_data_o, rs2_data_o  output  32 each  read data.
REQ-012 The block SHALL have port wb_data_o  output  32  selected writeback value, for forwarding.
REQ-013 The block SHALL have port wb_en_o  output  1  effective write enable this cycle.
REQ-014 The block SHALL have port wr_count_o  output  CNT_W  count of committed register writes.

Function
REQ-015 wb_data_o SHALL be combinational: data_dest 00 -> alu_result_i, 01 -> mem_rd_data_i, 10 -> pc_plus4_i, 11 -> 0.
REQ-016 wb_en_o SHALL be combinational: reg_wr_sig_i AND reg_wr_addr_i != 0 AND data_dest_i != 11.
REQ-017 On a rising clk with wb_en_o=1, register[reg_wr_addr_i] SHALL take wb_data_o; otherwise the array SHALL hold.
REQ-018 Register x0 SHALL always read 0; writes to x0 SHALL be discarded and SHALL NOT increment wr_count_o.
REQ-019 Reads SHALL be combinational, zero-latency, from the array.
REQ-020 Write-through bypass: when wb_en_o=1 and rsN_addr_i == reg_wr_addr_i, rsN_data_o SHALL equal wb_data_o in the same cycle.
REQ-021 rs1 and rs2 SHALL be independent; both may hit the bypass simultaneously with the same value.
REQ-022 wr_count_o SHALL increment by 1 on each rising clk with wb_en_o=1, and SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-023 Reserved data_dest 11 with reg_wr_sig_i=1 SHALL cause no write, no count, and no bypass.

Reset
REQ-024 While reset_n=0, all 31 writable registers and wr_count_o SHALL be 0 immediately, independent of clk.
REQ-025 While reset_n=0, rs1_data_o/rs2_data_o SHALL read 0 except via bypass of combinational inputs; no write SHALL commit.
REQ-026 A write coinciding with reset deassertion edge SHALL NOT commit; first commit is the first rising clk with reset_n=1.
REQ-027 Reset asserted mid-operation SHALL discard all register contents; no partial state SHALL survive.

Structure
REQ-028 Data_dest encodings (DEST_ALU=00, DEST_MEM=01, DEST_PC4=10, DEST_RSVD=11) SHALL reside in the shared pipeline package used by all stage registers.
REQ-029 The register array with bypass SHALL be a sub-module regfile_2r1w; the mux, enable qualification and counter SHALL be in wb_regfile.

Verification
REQ-030 Reset, then write alu 0x0000_00AA to x5 (dest 00), next cycle read rs1=5 -> 0x0000_00AA, wr_count_o=1.
REQ-031 reg_wr_sig=1, addr=0, dest 01, mem=0xDEAD_BEEF -> rs1=0 reads 0, wr_count_o unchanged.
REQ-032 Same-cycle write x7 <= pc_plus4 0x0000_1004 (dest 10) with rs1=rs2=7 -> both outputs 0x0000_1004 that cycle and after.
REQ-033 dest 11, reg_wr_sig=1, addr=3 -> wb_en_o=0, x3 keeps prior value, count unchanged.
REQ-034 Fill x1..x31 with index values, assert reset_n=0 mid-clock -> all reads 0 immediately, wr_count_o=0.
REQ-035 CNT_W=4, 16 valid writes from count 0 -> wr_count_o wraps to 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: the writeback source encodings used by every stage register.
package wb_regfile_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      DEST_ALU  = 2'b00,
      DEST_MEM  = 2'b01,
      DEST_PC4  = 2'b10,
      DEST_RSVD = 2'b11
   } data_dest_e;

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x 32-bit register array, two combinational read ports, one write port,
// with write-through bypass so a read of the register being written sees the new value.
module regfile_2r1w
   import wb_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data
);

   logic [XLEN-1:0] regs [NUM_REGS];
   logic            wr_valid;
   logic            rs1_hit;
   logic            rs2_hit;

   // x0 is hardwired: entry 0 is cleared by reset and never written afterwards
   assign wr_valid = wr_en && (wr_addr != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_valid && (wr_addr == REG_ADDR_W'(i))) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   assign rs1_hit  = wr_valid && (rs1_addr == wr_addr);
   assign rs2_hit  = wr_valid && (rs2_addr == wr_addr);
   assign rs1_data = rs1_hit ? wr_data : regs[rs1_addr];
   assign rs2_data = rs2_hit ? wr_data : regs[rs2_addr];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, qualifies the write enable,
// counts committed writes and drives the bypassed register file.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int CNT_W = 64
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [XLEN-1:0]       pc_plus4_i,
   input  logic [XLEN-1:0]       alu_result_i,
   input  logic [XLEN-1:0]       mem_rd_data_i,
   input  logic [1:0]            data_dest_i,
   input  logic [REG_ADDR_W-1:0] reg_wr_addr_i,
   input  logic                  reg_wr_sig_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic [XLEN-1:0]       rs1_data_o,
   output logic [XLEN-1:0]       rs2_data_o,
   output logic [XLEN-1:0]       wb_data_o,
   output logic                  wb_en_o,
   output logic [CNT_W-1:0]      wr_count_o
);

   data_dest_e       dest;
   logic [CNT_W-1:0] wr_count;

   assign dest = data_dest_e'(data_dest_i);

   // The reserved encoding yields zero so a stray bypass could never leak stale data
   always_comb begin
      wb_data_o = '0;
      unique case (dest)
         DEST_ALU:  wb_data_o = alu_result_i;
         DEST_MEM:  wb_data_o = mem_rd_data_i;
         DEST_PC4:  wb_data_o = pc_plus4_i;
         DEST_RSVD: wb_data_o = '0;
         default:   wb_data_o = '0;
      endcase
   end

   assign wb_en_o = reg_wr_sig_i && (reg_wr_addr_i != '0) && (dest != DEST_RSVD);

   // Free-running commit counter; wraps silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_count <= '0;
      end else if (wb_en_o) begin
         wr_count <= wr_count + CNT_W'(1);
      end
   end

   assign wr_count_o = wr_count;

   regfile_2r1w u_regfile (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wb_en_o),
      .wr_addr  (reg_wr_addr_i),
      .wr_data  (wb_data_o),
      .rs1_addr (rs1_addr_i),
      .rs2_addr (rs2_addr_i),
      .rs1_data (rs1_data_o),
      .rs2_data (rs2_data_o)
   );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven writeback/bypass vectors plus
// hand-written reset and counter-wrap sequences, with a 4-bit counter.
module tb_wb_regfile;

   logic        clk;
   logic        reset_n;
   logic [31:0] pc_plus4;
   logic [31:0] alu_result;
   logic [31:0] mem_rd_data;
   logic [1:0]  data_dest;
   logic [4:0]  reg_wr_addr;
   logic        reg_wr_sig;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_en;
   logic [3:0]  wr_count;

   int n_checks = 0;
   int n_fails  = 0;

   wb_regfile #(.CNT_W(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_plus4_i    (pc_plus4),
      .alu_result_i  (alu_result),
      .mem_rd_data_i (mem_rd_data),
      .data_dest_i   (data_dest),
      .reg_wr_addr_i (reg_wr_addr),
      .reg_wr_sig_i  (reg_wr_sig),
      .rs1_addr_i    (rs1_addr),
      .rs2_addr_i    (rs2_addr),
      .rs1_data_o    (rs1_data),
      .rs2_data_o    (rs2_data),
      .wb_data_o     (wb_data),
      .wb_en_o       (wb_en),
      .wr_count_o    (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sig;
      logic [4:0]  addr;
      logic [1:0]  dest;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] pc4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] exp_wb;
      logic        exp_en;
      logic [31:0] exp_rs1;
      logic [31:0] exp_rs2;
      logic [3:0]  exp_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic applyStimulus(input logic sig, input logic [4:0] addr, input logic [1:0] dest,
                                input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                                input logic [4:0] rs1, input logic [4:0] rs2);
      reg_wr_sig  = sig;
      reg_wr_addr = addr;
      data_dest   = dest;
      alu_result  = alu;
      mem_rd_data = mem;
      pc_plus4    = pc4;
      rs1_addr    = rs1;
      rs2_addr    = rs2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      applyStimulus(1'b1, addr, 2'b00, data, 32'h0, 32'h0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // sig addr dest alu mem pc4 rs1 rs2 | wb en rs1 rs2 cnt_after
      vecs[0]  = '{1'b1, 5'd5,  2'b00, 32'h0000_00AA, 32'h0,         32'h0,         5'd5,  5'd0,
                   32'h0000_00AA, 1'b1, 32'h0000_00AA, 32'h0,         4'd1};
      vecs[1]  = '{1'b0, 5'd5,  2'b00, 32'h0000_1234, 32'h0,         32'h0,         5'd5,  5'd5,
                   32'h0000_1234, 1'b0, 32'h0000_00AA, 32'h0000_00AA, 4'd1};
      vecs[2]  = '{1'b1, 5'd0,  2'b01, 32'h0,         32'hDEAD_BEEF, 32'h0,         5'd0,  5'd5,
                   32'hDEAD_BEEF, 1'b0, 32'h0,         32'h0000_00AA, 4'd1};
      vecs[3]  = '{1'b1, 5'd7,  2'b10, 32'h0,         32'h0,         32'h0000_1004, 5'd7,  5'd7,
                   32'h0000_1004, 1'b1, 32'h0000_1004, 32'h0000_1004, 4'd2};
      vecs[4]  = '{1'b0, 5'd0,  2'b00, 32'h0,         32'h0,         32'h0,         5'd7,  5'd7,
                   32'h0,         1'b0, 32'h0000_1004, 32'h0000_1004, 4'd2};
      vecs[5]  = '{1'b1, 5'd3,  2'b01, 32'h0,         32'h3333_3333, 32'h0,         5'd3,  5'd7,
                   32'h3333_3333, 1'b1, 32'h3333_3333, 32'h0000_1004, 4'd3};
      vecs[6]  = '{1'b1, 5'd3,  2'b11, 32'h0000_FFFF, 32'h0000_EEEE, 32'h0000_DDDD, 5'd3,  5'd3,
                   32'h0,         1'b0, 32'h3333_3333, 32'h3333_3333, 4'd3};
      vecs[7]  = '{1'b1, 5'd3,  2'b00, 32'h0000_0001, 32'h0,         32'h0,         5'd3,  5'd5,
                   32'h0000_0001, 1'b1, 32'h0000_0001, 32'h0000_00AA, 4'd4};
      vecs[8]  = '{1'b0, 5'd3,  2'b00, 32'h0000_0055, 32'h0,         32'h0,         5'd3,  5'd31,
                   32'h0000_0055, 1'b0, 32'h0000_0001, 32'h0,         4'd4};
      vecs[9]  = '{1'b1, 5'd31, 2'b10, 32'h0,         32'h0,         32'hFFFF_FFFC, 5'd30, 5'd31,
                   32'hFFFF_FFFC, 1'b1, 32'h0,         32'hFFFF_FFFC, 4'd5};
      vecs[10] = '{1'b0, 5'd0,  2'b00, 32'h0,         32'h0,         32'h0,         5'd31, 5'd5,
                   32'h0,         1'b0, 32'hFFFF_FFFC, 32'h0000_00AA, 4'd5};

      reset_n = 1'b0;
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("reset_count", 32'(wr_count), 32'h0);
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
      #1;
      checkOutput("reset_rs1", rs1_data, 32'h0);
      checkOutput("reset_rs2", rs2_data, 32'h0);

      // Table-driven writeback, enable qualification and bypass
      for (int v = 0; v < 11; v++) begin
         @(negedge clk);
         applyStimulus(vecs[v].sig, vecs[v].addr, vecs[v].dest, vecs[v].alu, vecs[v].mem,
                       vecs[v].pc4, vecs[v].rs1, vecs[v].rs2);
         #1;
         checkOutput($sformatf("vec%0d_wb_data", v), wb_data, vecs[v].exp_wb);
         checkOutput($sformatf("vec%0d_wb_en", v), 32'(wb_en), 32'(vecs[v].exp_en));
         checkOutput($sformatf("vec%0d_rs1", v), rs1_data, vecs[v].exp_rs1);
         checkOutput($sformatf("vec%0d_rs2", v), rs2_data, vecs[v].exp_rs2);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_count", v), 32'(wr_count), 32'(vecs[v].exp_cnt));
      end

      // Fill x1..x31 with their index, read them all back
      for (int i = 1; i < 32; i++) begin
         writeReg(5'(i), 32'(i));
      end
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      for (int i = 1; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(32 - i);
         #1;
         checkOutput($sformatf("fill_rs1_x%0d", i), rs1_data, 32'(i));
         checkOutput($sformatf("fill_rs2_x%0d", 32 - i), rs2_data, 32'(32 - i));
      end
      checkOutput("fill_count", 32'(wr_count), 32'd4);

      // Reset asserted between clock edges clears everything at once
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_count", 32'(wr_count), 32'h0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         checkOutput($sformatf("midreset_rs1_x%0d", i), rs1_data, 32'h0);
         checkOutput($sformatf("midreset_rs2_x%0d", 31 - i), rs2_data, 32'h0);
      end

      // Bypass of combinational inputs is still visible while in reset, but nothing commits
      applyStimulus(1'b1, 5'd9, 2'b00, 32'h0000_0099, 32'h0, 32'h0, 5'd9, 5'd10);
      #1;
      checkOutput("inreset_bypass_rs1", rs1_data, 32'h0000_0099);
      checkOutput("inreset_rs2", rs2_data, 32'h0);
      checkOutput("inreset_wb_en", 32'(wb_en), 32'h1);
      @(posedge clk);
      #1;
      checkOutput("inreset_count", 32'(wr_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9);
      #1;
      checkOutput("postreset_x9", rs1_data, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("postreset_count", 32'(wr_count), 32'h0);

      writeReg(5'd9, 32'h0000_0099);
      checkOutput("first_commit_count", 32'(wr_count), 32'd1);
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd9, 5'd10);
      #1;
      checkOutput("first_commit_x9", rs1_data, 32'h0000_0099);
      checkOutput("first_commit_x10", rs2_data, 32'h0);

      // Counter wraps from 15 to 0 with no side effect
      for (int k = 1; k <= 15; k++) begin
         writeReg(5'(9 + k), 32'(k));
         checkOutput($sformatf("wrap_count_%0d", k), 32'(wr_count), 32'((1 + k) % 16));
      end
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd24, 5'd10);
      #1;
      checkOutput("wrap_x24", rs1_data, 32'd15);
      checkOutput("wrap_x10", rs2_data, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
